// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic [31:0] OUT_ADDR_DEFAULT = 32'h1000_0000;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Request captured from the winning port in IDLE.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin picker with a last-grant pointer.
// Latency: pick is combinational; pointer updates on the clock edge where advance is high.
// Backpressure: a losing request simply stays pending; the next contest favours it.
//
// Ports: clk/resetn; req[1:0] request vector; advance commits the current pick
// to the pointer; gnt_vld = any request; gnt_idx = winning port.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_vld = |req;
    if (req == 2'b11) begin
      // Contest: whoever did not win last time goes first.
      gnt_idx = ~last_q;
    end else if (req[0]) begin
      gnt_idx = PORT0;
    end else begin
      gnt_idx = PORT1;
    end
  end

  // Pointer starts at port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= PORT1;
    end else if (advance && gnt_vld) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one sync-read word SRAM and an output-byte register between two valid/ready masters.
// Latency: valid sampled in IDLE at N -> ram_en at N+1 -> ready pulse at N+2; one access per 3 cycles.
// Backpressure: requester holds valid until its ready pulse; the loser of a contest waits one access.
//
// Ports: clk, resetn (async, active-low); m0_*/m1_* master request/response
// (valid, addr, wdata, wstrb in; ready, rdata out); ram_* SRAM access
// (en, we, addr, wdata out; rdata in, valid the cycle after a read);
// out_byte / out_byte_en output-byte register and its update strobe.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          MEM_SIZE = 4096,
  parameter int          ADDR_W   = $clog2(MEM_SIZE),
  parameter logic [31:0] OUT_ADDR = OUT_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,

  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,

  output logic [7:0]        out_byte,
  output logic              out_byte_en
);

  arb_state_t  state_q, state_d;
  req_t        req_q;
  logic        gnt_q;
  logic        gnt_vld, gnt_idx;
  logic        ram_hit, is_out, is_write;
  logic [31:0] resp_data;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({m1_valid, m0_valid}),
    .advance (state_q == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Decode works only on the latched request, so RAM strobes never depend
  // on a master's live valid/addr.
  assign ram_hit  = (req_q.addr >> 2) < 32'(MEM_SIZE);
  assign is_out   = (req_q.addr == OUT_ADDR);
  assign is_write = |req_q.wstrb;

  // Out-of-range, output-register and write accesses all read back as zero.
  assign resp_data = (ram_hit && !is_write) ? ram_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en      = 1'b0;
    ram_we      = 4'h0;
    ram_addr    = '0;
    ram_wdata   = 32'h0;
    out_byte_en = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (ram_hit) begin
          ram_en    = 1'b1;
          ram_we    = req_q.wstrb;
          ram_addr  = req_q.addr[ADDR_W+1:2];
          ram_wdata = req_q.wdata;
        end
        if (is_out && is_write) begin
          out_byte_en = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (gnt_q == PORT0) begin
          m0_ready = 1'b1;
        end else begin
          m1_ready = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's request as it leaves IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q <= '0;
      gnt_q <= PORT0;
    end else if (state_q == ST_IDLE && gnt_vld) begin
      gnt_q <= gnt_idx;
      if (gnt_idx == PORT0) begin
        req_q <= '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
      end else begin
        req_q <= '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_byte <= 8'h00;
    end else if (out_byte_en) begin
      out_byte <= req_q.wdata[7:0];
    end
  end

  // The SRAM only presents read data during RESP, which is also the ready
  // cycle. So rdata passes the response through while ready is high, and a
  // register holds that value afterwards until the port's next response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      if (m0_ready) m0_rdata_q <= resp_data;
      if (m1_ready) m1_rdata_q <= resp_data;
    end
  end

  assign m0_rdata = m0_ready ? resp_data : m0_rdata_q;
  assign m1_rdata = m1_ready ? resp_data : m1_rdata_q;

endmodule
